// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port load/store arbiter and sequencer for the single-port
// data memory. Port 0 is the core LSU, port 1 the debug/loader port.
// Each transaction takes an ACCESS cycle (memory driven) followed by a RESP
// cycle (registered response pulse); a new request can be accepted in RESP.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, port 0 always wins a tie.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              id_q, id_d;
  logic [1:0]        respValid_q, respValid_d;
  logic [DATA_W-1:0] respRdata_q, respRdata_d;
  logic              respErr_q, respErr_d;

  logic grantId;
  logic accept;
  logic aligned;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Round-robin: the pointer breaks ties, a lone requester always wins
  always_comb begin
    grantId = (&req_valid) ? ptr_q : req_valid[1];
    ptr_d   = accept ? ~grantId : ptr_q;
  end

  // Preferred-port pointer, starts at port 0
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting
  always_comb begin
    grantId = ~req_valid[0];
  end
`endif

  assign accept    = (state_q != ACCESS) && (|req_valid);
  assign req_ready = accept ? (grantId ? 2'b10 : 2'b01) : 2'b00;

  assign aligned     = (addr_q[1:0] == 2'b00);
  assign mem_address = addr_q;
  assign mem_wd      = data_q;
  assign mem_wr      = (state_q == ACCESS) && wr_q && aligned && !reset;

  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

  // Sequencing: latch the winner's request on accept, access memory, respond
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    id_d        = id_q;
    respValid_d = 2'b00;
    respRdata_d = respRdata_q;
    respErr_d   = respErr_q;
    case (state_q)
      ACCESS: begin
        state_d     = RESP;
        respValid_d = id_q ? 2'b10 : 2'b01;
        respRdata_d = (!wr_q && aligned) ? mem_rd : '0;
        respErr_d   = !aligned;
      end
      default: begin
        if (accept) begin
          state_d = ACCESS;
          addr_d  = grantId ? req_addr1  : req_addr0;
          data_d  = grantId ? req_wdata1 : req_wdata0;
          wr_d    = grantId ? req_wr[1]  : req_wr[0];
          id_d    = grantId;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, latched request and registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      id_q        <= 1'b0;
      respValid_q <= 2'b00;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      id_q        <= id_d;
      respValid_q <= respValid_d;
      respRdata_q <= respRdata_d;
      respErr_q   <= respErr_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration, latency and memory.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wd;
  logic        mem_wr;
  logic [31:0] mem_rd;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_wd(mem_wd), .mem_wr(mem_wr),
    .mem_rd(mem_rd)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory seen by the DUT: combinational read, word write on the clock edge
  logic [31:0] tbMem [0:63];
  assign mem_rd = tbMem[mem_address[7:2]];
  always @(posedge clock) begin
    if (mem_wr === 1'b1) tbMem[mem_address[7:2]] <= mem_wd;
  end

  // Reference model state
  bit [31:0] refMem [0:63];
  int        preferred;
  int        cyc;
  int        accCycle, respCycle;
  int        accPort;
  bit [31:0] accAddr, accData;
  bit        accWr;
  bit [1:0]  expRespValid;
  bit [31:0] expRdata;
  bit        expErr;
  int        grantLog[$];
  int        respSeen0;

  // Requests held by each port until accepted
  bit        pendValid [2];
  bit        pendWr    [2];
  bit [31:0] pendAddr  [2];
  bit [31:0] pendData  [2];

  int checkCount;
  int passCount;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Arbitration rule: lone requester wins; ties go to the preferred port
  function automatic int pickWinner(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return preferred;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic void setRequest(input int p, input bit wr, input bit [31:0] addr, input bit [31:0] data);
    pendValid[p] = 1'b1;
    pendWr[p]    = wr;
    pendAddr[p]  = addr;
    pendData[p]  = data;
  endfunction

  // One clock cycle: check outputs, drive the pending requests, predict the grant
  task automatic applyStimulus(input bit randomFill);
    int        w;
    bit        isAligned;
    bit        expWr;
    bit [1:0]  expReady;
    @(negedge clock);
    if (resp_valid[0] === 1'b1) respSeen0++;
    if (cyc == respCycle) begin
      checkOutput("resp_valid", {30'd0, resp_valid}, {30'd0, expRespValid});
      checkOutput("resp_rdata", resp_rdata, expRdata);
      checkOutput("resp_err", {31'd0, resp_err}, {31'd0, expErr});
    end else begin
      checkOutput("resp_valid quiet", {30'd0, resp_valid}, 32'd0);
    end
    if (cyc == accCycle) begin
      isAligned = (accAddr % 4) == 0;
      expWr     = accWr && isAligned;
      checkOutput("mem_address", mem_address, accAddr);
      checkOutput("mem_wr access", {31'd0, mem_wr}, {31'd0, expWr});
      if (expWr) checkOutput("mem_wd", mem_wd, accData);
      expRespValid = (accPort == 1) ? 2'b10 : 2'b01;
      expErr       = !isAligned;
      expRdata     = (!accWr && isAligned) ? refMem[accAddr / 4] : 32'd0;
      if (expWr) refMem[accAddr / 4] = accData;
    end else begin
      checkOutput("mem_wr quiet", {31'd0, mem_wr}, 32'd0);
    end
    if (randomFill) begin
      for (int p = 0; p < 2; p++) begin
        if (!pendValid[p] && ($urandom_range(0, 1) == 1)) begin
          setRequest(p, 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 15)) * 4 +
                     (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0),
                     $urandom);
        end
      end
    end
    req_valid  = {pendValid[1], pendValid[0]};
    req_wr     = {pendWr[1], pendWr[0]};
    req_addr0  = pendAddr[0];
    req_addr1  = pendAddr[1];
    req_wdata0 = pendData[0];
    req_wdata1 = pendData[1];
    #1;
    w = (cyc == accCycle) ? -1 : pickWinner(pendValid[0], pendValid[1]);
    expReady = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
    checkOutput("req_ready", {30'd0, req_ready}, {30'd0, expReady});
    if (w >= 0) begin
      accPort   = w;
      accAddr   = pendAddr[w];
      accData   = pendData[w];
      accWr     = pendWr[w];
      accCycle  = cyc + 1;
      respCycle = cyc + 2;
      preferred = 1 - w;
      pendValid[w] = 1'b0;
      grantLog.push_back(w);
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic flush();
    repeat (4) applyStimulus(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbMem[i]  = 32'd0;
      refMem[i] = 32'd0;
    end
    checkCount = 0;
    passCount  = 0;
    preferred  = 0;
    cyc        = 0;
    accCycle   = -100;
    respCycle  = -100;
    respSeen0  = 0;
    for (int p = 0; p < 2; p++) begin
      pendValid[p] = 1'b0;
      pendWr[p]    = 1'b0;
      pendAddr[p]  = 32'd0;
      pendData[p]  = 32'd0;
    end
    req_valid = 2'b00; req_wr = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rst resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst mem_address", mem_address, 32'd0);
    checkOutput("rst mem_wd", mem_wd, 32'd0);

    $display("[TB] both ports requesting continuously");
    grantLog.delete();
    for (int n = 0; n < 40 && grantLog.size() < 8; n++) begin
      if (!pendValid[0]) setRequest(0, 1'b0, 32'h0, 32'd0);
      if (!pendValid[1]) setRequest(1, 1'b0, 32'h4, 32'd0);
      applyStimulus(1'b0);
    end
    checkOutput("grant count", 32'(grantLog.size()), 32'd8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      checkOutput("grant order", 32'(grantLog[i]), 32'(i % 2));
`else
      checkOutput("grant order", 32'(grantLog[i]), 32'd0);
`endif
    end
    pendValid[0] = 1'b0;
    pendValid[1] = 1'b0;
    flush();

    $display("[TB] store then load through different ports");
    setRequest(0, 1'b1, 32'h10, 32'hDEADBEEF);
    flush();
    checkOutput("mem 0x10 written", tbMem[4], 32'hDEADBEEF);
    setRequest(1, 1'b0, 32'h10, 32'd0);
    flush();

    $display("[TB] misaligned load, then aligned load");
    setRequest(0, 1'b0, 32'h13, 32'd0);
    flush();
    setRequest(0, 1'b1, 32'h16, 32'h55555555);
    flush();
    setRequest(0, 1'b0, 32'h10, 32'd0);
    flush();
    checkOutput("mem 0x10 intact", tbMem[4], 32'hDEADBEEF);

    $display("[TB] back-to-back port 0 loads");
    respSeen0 = 0;
    for (int n = 0; n < 10; n++) begin
      if (!pendValid[0]) setRequest(0, 1'b0, 32'h10, 32'd0);
      applyStimulus(1'b0);
    end
    checkOutput("b2b responses", 32'(respSeen0), 32'd4);
    flush();

    $display("[TB] reset during store access");
    setRequest(0, 1'b1, 32'h20, 32'h12345678);
    applyStimulus(1'b0);
    @(negedge clock);
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    checkOutput("mem_wr under reset", {31'd0, mem_wr}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("post-rst resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("post-rst resp_rdata", resp_rdata, 32'd0);
    checkOutput("post-rst resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("post-rst mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("post-rst mem_address", mem_address, 32'd0);
    checkOutput("post-rst mem_wd", mem_wd, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post-rst req_ready", {30'd0, req_ready}, 32'd0);
    accCycle  = -100;
    respCycle = -100;
    preferred = 0;
    checkOutput("mem 0x20 unchanged", tbMem[8], 32'd0);
    setRequest(0, 1'b0, 32'h20, 32'd0);
    flush();

    $display("[TB] randomized traffic");
    repeat (400) applyStimulus(1'b1);
    for (int n = 0; n < 6; n++) applyStimulus(1'b0);
    flush();
    for (int i = 0; i < 16; i++) checkOutput("final memory", tbMem[i], refMem[i]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed, single-port data memory (word write on clock edge, combinational word read). It accepts load/store requests from two requesters: port 0 is the Beta core load/store unit, port 1 is the debug/loader port. It serialises them onto the memory port, checks word alignment, and returns registered read data with a per-port response pulse.

## Interface
- Parameters:
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width; fixed at 32 (4 bytes/word)
- Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-port request valid (bit i = port i)
- `req_wr`  in  2  per-port 1 = store, 0 = load
- `req_addr0`, `req_addr1`  in  ADDR_W  per-port byte address
- `req_wdata0`, `req_wdata1`  in  DATA_W  per-port store data
- `req_ready`  out  2  per-port accept; a transfer happens when valid & ready at a rising edge
- `resp_valid`  out  2  per-port one-cycle response pulse
- `resp_rdata`  out  DATA_W  load data, shared, qualified by `resp_valid`
- `resp_err`  out  1  misaligned access, qualified by `resp_valid`
- `mem_address`  out  ADDR_W  to memory address
- `mem_wd`  out  DATA_W  to memory write data
- `mem_wr`  out  1  to memory write enable
- `mem_rd`  in  DATA_W  from memory read data (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE or RESP: the arbiter selects a winner among the asserted `req_valid` bits. `req_ready` is high only for the winner, and its address, data, direction and port id are latched. On accept, go to ACCESS; otherwise go (or stay) IDLE.
- ACCESS: the latched address drives `mem_address`, and the latched data drives `mem_wd`.
  - `mem_wr` = latched wr & aligned & !reset.
  - Load: `mem_rd` is registered into `resp_rdata`.
  - Misaligned (addr[1:0] != 0): no write; `resp_rdata` = 0; `resp_err` = 1.
  - Always go to RESP.
- RESP: `resp_valid[id]` = 1 for exactly this cycle. Stores also respond, with `resp_rdata` = 0. The next request may be accepted in this same cycle.
- `req_ready` never asserts in ACCESS.
- A requester must hold valid/addr/wdata/wr stable until accepted. The arbiter holds no state for unaccepted requests.
- `mem_address`/`mem_wd` hold the last latched values outside ACCESS. `mem_wr` is 0 outside ACCESS.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0
  - `mem_wr` = 0, `mem_address` = 0, `mem_wd` = 0
  - priority pointer = port 0
- Latency: accept at edge N → ACCESS in cycle N+1 → `resp_valid` in cycle N+2.
- Throughput: one transaction per 2 cycles, back-to-back through RESP.
- Simultaneous requests: resolved by the arbitration policy (see Configuration). The loser's `req_ready` stays 0.
- Reset asserted during ACCESS: `mem_wr` is forced 0 that cycle (no partial write). No response is issued; the FSM returns to IDLE.
- Reset asserted during RESP: `resp_valid` is still 0 after the edge.
- `req_ready` is combinational from state, `req_valid` and the pointer. `resp_*` outputs are registered.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After a grant to port i, the pointer becomes 1-i.
  - A lone requester always wins.
- Not defined: fixed priority; port 0 always wins a tie. The pointer logic is absent.

## Test plan
- Store 0xDEADBEEF at 0x10 via port 0, then load 0x10 via port 1 → store `resp_valid[0]` at N+2 with `resp_err` = 0; load returns `resp_rdata` = 0xDEADBEEF on `resp_valid[1]`.
- Load at 0x13 via port 0 → `mem_wr` never 1, `resp_err` = 1, `resp_rdata` = 0. A subsequent aligned load of 0x10 still returns 0xDEADBEEF.
- Both ports hold `req_valid` continuously for 8 grants:
  - with `DMEM_ARB_ROUND_ROBIN_EN`, grant order is 0,1,0,1,…;
  - without it, all grants go to port 0.
- Back-to-back port 0 loads → `req_ready[0]` high in each RESP cycle; `resp_valid[0]` every 2nd cycle.
- Reset asserted in the ACCESS cycle of a store of 0x12345678 to 0x20 → no `mem_wr` pulse, no `resp_valid`. After reset: outputs 0, state IDLE, and memory at 0x20 is unchanged.
